seq_lut_engine: RTL
===================

Name: seq_lut_engine

Overview:
- Parametrised, programmable sequence engine. It walks a chain of LUT RAM entries, running each step's task code for a programmed number of iterations, then following the entry's next-address link.
- It adds explicit-address host programming, per-task done channels, real repeat counting, a watchdog timeout and abort.
- It sits between the host command/register block and the panel task controllers (reset, stabilise, bias, flush, expose, readout, AED).

Parameters:
TASK_W, 3, width of task code; NUM_TASKS = 2**TASK_W done channels
DEPTH, 256, LUT entries; ADDR_W = $clog2(DEPTH)
REPEAT_W, 8, repeat-count field width
LEN_W, 16, data-length field width
TMO_W, 24, watchdog counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_i  in  1  start pulse; honoured in IDLE only
start_addr_i  in  ADDR_W  first entry of the sequence
abort_i  in  1  abort; returns to IDLE from any state
task_done_i  in  NUM_TASKS  per-task done strobe
timeout_cycles_i  in  TMO_W  watchdog limit; 0 disables it
lut_wr_en_i  in  1  host write strobe
lut_rd_en_i  in  1  host read strobe
lut_addr_i  in  ADDR_W  host address
lut_wr_data_i  in  ENTRY_W  host write data
lut_rd_data_o  out  ENTRY_W  host read data
lut_rd_valid_o  out  1  read data valid pulse
lut_err_o  out  1  pulse: host access attempted while busy
state_o  out  3  engine state
busy_o  out  1  state != IDLE
task_o  out  TASK_W  active task code
task_start_o  out  1  pulse at the start of each task iteration
step_addr_o  out  ADDR_W  address of the current entry
iter_o  out  REPEAT_W  current iteration index (0-based)
data_length_o  out  LEN_W  length field of the current entry
sof_o  out  1  sof flag of the current entry
eof_o  out  1  eof flag of the current entry
sequence_done_o  out  1  pulse: last entry completed
timeout_o  out  1  pulse on watchdog expiry
error_o  out  1  sticky; high while in ERROR

Behaviour:
- Entry layout, MSB to LSB: {last, sof, eof, len[LEN_W], repeat[REPEAT_W], task[TASK_W], next[ADDR_W]}. ENTRY_W = 3 + LEN_W + REPEAT_W + TASK_W + ADDR_W (38 at defaults).
- RAM: single-port, synchronous read, 1-cycle latency.
  - The RAM is not reset; contents survive reset.
  - The host owns the port in IDLE; the engine owns it otherwise.
- Reset: state_o = IDLE (0). Every other output and internal register is 0.
- Host access in IDLE:
  - Write: lut_wr_en_i writes the RAM at the next edge.
  - Read: lut_rd_en_i gives lut_rd_data_o and a lut_rd_valid_o pulse one cycle later.
  - lut_rd_data_o holds its value until the next read.
  - Simultaneous wr and rd: the write wins and no valid pulse is produced.
- Host access outside IDLE: the access is ignored and lut_err_o pulses for one cycle.
- States (encoding): IDLE=0, FETCH=1, LOAD=2, RUN=3, DONE=4, ERROR=5; codes 6 and 7 go to IDLE.
- IDLE:
  - start_i with abort_i low latches addr = start_addr_i and goes to FETCH.
  - If a host access and start_i arrive together, the access is serviced and start_i is honoured.
- FETCH: the read of addr is issued; go to LOAD.
- LOAD: latch all entry fields, set iter = 0, clear the watchdog, go to RUN.
- RUN:
  - task_start_o pulses on the first RUN cycle of each iteration.
  - When task_done_i[task] is high and iter < repeat: iter++, clear the watchdog, and task_start_o pulses next cycle.
  - When task_done_i[task] is high and iter == repeat: if last, go to DONE; otherwise addr = next, go to FETCH.
  - repeat = 0 means exactly one run.
- Done strobes: strobes on other channels are ignored. A done strobe in the same cycle as task_start_o counts.
- Watchdog: counts RUN cycles within an iteration. At count == timeout_cycles_i (non-zero), go to ERROR and pulse timeout_o.
  - Done and expiry in the same cycle: done wins.
  - The counter saturates at its maximum.
- DONE: sequence_done_o pulses for one cycle; go to IDLE.
- ERROR: error_o = 1. Stays until abort_i; start_i is ignored.
- abort_i in any non-IDLE state: IDLE next cycle, no sequence_done_o, error_o cleared. abort_i in IDLE takes priority over start_i.
- Self-linking entries (next == addr) and cycles are legal. They run continuously until abort_i.
- Address arithmetic wraps modulo DEPTH. The iteration compare is unsigned, REPEAT_W bits.
- Reset mid-sequence: IDLE next cycle; the in-flight task is abandoned.
- Overall latency from start to the first task_start_o: 3 cycles (FETCH, LOAD, RUN). The next-entry gap is 2 cycles.

Decomposition:
- Package seq_lut_pkg holds:
  - the engine state enum;
  - the entry field offsets and the ENTRY_W function;
  - a packed entry struct typedef, parametrised via localparams at default widths.
- Sub-module seq_lut_ram: single-port synchronous RAM with DEPTH and ENTRY_W parameters and no reset.

Test Plan:
- Host writes entry 5 = {last=1, sof=1, eof=1, len=0x0200, rep=0, task=4, next=0}, then reads 5 -> lut_rd_valid_o one cycle later with identical data.
- start_i, start_addr_i=5, task_done_i[4] pulsed 10 cycles after task_start_o -> task_start_o 3 cycles after start, data_length_o=0x0200, sequence_done_o pulses, busy_o falls the cycle after.
- Chain 1->2 (entry 1: rep=2, task=1, next=2; entry 2: last=1, task=6) -> three task_start_o pulses with iter_o 0,1,2, then step_addr_o=2, task_o=6; task_done_i[3] strobes are ignored.
- timeout_cycles_i=50, no done -> timeout_o pulses after 50 RUN cycles, error_o=1; start_i ignored; abort_i returns to IDLE with error_o=0.
- Write while busy -> lut_err_o pulses and RAM is unchanged (readback after abort).
- Self-link entry, reset asserted mid-RUN -> IDLE with all outputs 0; RAM contents preserved on readback.

Source files
------------

// File: rtl/seq_lut_pkg.sv
// Shared types for the LUT-driven sequence engine: engine states, entry field
// offsets and a packed view of one LUT entry at the default field widths.
package seq_lut_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } engine_state_e;

    localparam int DEF_TASK_W   = 3;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_REPEAT_W = 8;
    localparam int DEF_LEN_W    = 16;
    localparam int DEF_TMO_W    = 24;
    localparam int DEF_ADDR_W   = $clog2(DEF_DEPTH);

    // Entry layout, MSB to LSB: {last, sof, eof, len, repeat, task, next}
    function automatic int entryWidth(input int lenW, input int repW,
                                      input int taskW, input int addrW);
        return 3 + lenW + repW + taskW + addrW;
    endfunction

    function automatic int taskLsb(input int addrW);
        return addrW;
    endfunction

    function automatic int repLsb(input int taskW, input int addrW);
        return addrW + taskW;
    endfunction

    function automatic int lenLsb(input int repW, input int taskW, input int addrW);
        return addrW + taskW + repW;
    endfunction

    function automatic int eofBit(input int lenW, input int repW,
                                  input int taskW, input int addrW);
        return addrW + taskW + repW + lenW;
    endfunction

    typedef struct packed {
        logic                    last;
        logic                    sof;
        logic                    eof;
        logic [DEF_LEN_W-1:0]    len;
        logic [DEF_REPEAT_W-1:0] repeatCnt;
        logic [DEF_TASK_W-1:0]   taskCode;
        logic [DEF_ADDR_W-1:0]   nextAddr;
    } seq_entry_t;

endpackage

// File: rtl/seq_lut_ram.sv
// Single-port LUT RAM with a registered read port; contents are never reset
// so a programmed sequence survives an engine reset.
module seq_lut_ram #(
    parameter int DEPTH   = 256,
    parameter int ENTRY_W = 38,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic               re_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] rdData_q;

    // A write owns the port for its cycle, so the read register keeps its old value
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdData_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdData_q;

endmodule

// File: rtl/seq_lut_engine.sv
// Programmable sequence engine: walks linked LUT entries, runs each entry's task
// for repeat+1 iterations, with host programming, watchdog timeout and abort.
module seq_lut_engine
    import seq_lut_pkg::*;
#(
    parameter int TASK_W    = DEF_TASK_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int REPEAT_W  = DEF_REPEAT_W,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int TMO_W     = DEF_TMO_W,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int NUM_TASKS = 2**TASK_W,
    localparam int ENTRY_W   = entryWidth(LEN_W, REPEAT_W, TASK_W, ADDR_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    start_addr_i,
    input  logic                 abort_i,
    input  logic [NUM_TASKS-1:0] task_done_i,
    input  logic [TMO_W-1:0]     timeout_cycles_i,
    input  logic                 lut_wr_en_i,
    input  logic                 lut_rd_en_i,
    input  logic [ADDR_W-1:0]    lut_addr_i,
    input  logic [ENTRY_W-1:0]   lut_wr_data_i,
    output logic [ENTRY_W-1:0]   lut_rd_data_o,
    output logic                 lut_rd_valid_o,
    output logic                 lut_err_o,
    output logic [2:0]           state_o,
    output logic                 busy_o,
    output logic [TASK_W-1:0]    task_o,
    output logic                 task_start_o,
    output logic [ADDR_W-1:0]    step_addr_o,
    output logic [REPEAT_W-1:0]  iter_o,
    output logic [LEN_W-1:0]     data_length_o,
    output logic                 sof_o,
    output logic                 eof_o,
    output logic                 sequence_done_o,
    output logic                 timeout_o,
    output logic                 error_o
);

    localparam int TASK_LSB = taskLsb(ADDR_W);
    localparam int REP_LSB  = repLsb(TASK_W, ADDR_W);
    localparam int LEN_LSB  = lenLsb(REPEAT_W, TASK_W, ADDR_W);
    localparam int EOF_BIT  = eofBit(LEN_W, REPEAT_W, TASK_W, ADDR_W);
    localparam int SOF_BIT  = EOF_BIT + 1;
    localparam int LAST_BIT = EOF_BIT + 2;

    engine_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   next_q, next_d;
    logic [TASK_W-1:0]   task_q, task_d;
    logic [REPEAT_W-1:0] repeat_q, repeat_d;
    logic [REPEAT_W-1:0] iter_q, iter_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                last_q, last_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;
    logic [TMO_W-1:0]    wdog_q, wdog_d;
    logic                taskStart_q, taskStart_d;
    logic                timeout_q, timeout_d;
    logic                lutErr_q, lutErr_d;
    logic                rdValid_q, rdValid_d;
    logic [ENTRY_W-1:0]  hostRdData_q, hostRdData_d;

    logic                ramWe;
    logic                ramRe;
    logic [ADDR_W-1:0]   ramAddr;
    logic [ENTRY_W-1:0]  ramRdata;
    logic [TMO_W-1:0]    wdogInc;
    logic                taskDone;
    logic                hostAccess;

    seq_lut_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ramWe),
        .re_i    (ramRe),
        .addr_i  (ramAddr),
        .wdata_i (lut_wr_data_i),
        .rdata_o (ramRdata)
    );

    assign wdogInc    = (wdog_q == {TMO_W{1'b1}}) ? wdog_q : wdog_q + TMO_W'(1);
    assign taskDone   = task_done_i[task_q];
    assign hostAccess = lut_wr_en_i | lut_rd_en_i;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        next_d       = next_q;
        task_d       = task_q;
        repeat_d     = repeat_q;
        iter_d       = iter_q;
        len_d        = len_q;
        last_d       = last_q;
        sof_d        = sof_q;
        eof_d        = eof_q;
        wdog_d       = wdog_q;
        taskStart_d  = 1'b0;
        timeout_d    = 1'b0;
        lutErr_d     = 1'b0;
        rdValid_d    = 1'b0;
        hostRdData_d = rdValid_q ? ramRdata : hostRdData_q;
        ramWe        = 1'b0;
        ramRe        = 1'b0;
        ramAddr      = addr_q;

        case (state_q)
            ST_IDLE: begin
                ramAddr   = lut_addr_i;
                ramWe     = lut_wr_en_i;
                ramRe     = lut_rd_en_i & ~lut_wr_en_i;
                rdValid_d = lut_rd_en_i & ~lut_wr_en_i;
                if (start_i && !abort_i) begin
                    addr_d  = start_addr_i;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ramRe   = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                last_d      = ramRdata[LAST_BIT];
                sof_d       = ramRdata[SOF_BIT];
                eof_d       = ramRdata[EOF_BIT];
                len_d       = ramRdata[LEN_LSB +: LEN_W];
                repeat_d    = ramRdata[REP_LSB +: REPEAT_W];
                task_d      = ramRdata[TASK_LSB +: TASK_W];
                next_d      = ramRdata[0 +: ADDR_W];
                iter_d      = '0;
                wdog_d      = '0;
                taskStart_d = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A done strobe outranks a watchdog expiry in the same cycle
                if (taskDone) begin
                    if (iter_q < repeat_q) begin
                        iter_d      = iter_q + REPEAT_W'(1);
                        wdog_d      = '0;
                        taskStart_d = 1'b1;
                    end else if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = next_q;
                        state_d = ST_FETCH;
                    end
                end else begin
                    wdog_d = wdogInc;
                    if (timeout_cycles_i != '0 && wdogInc == timeout_cycles_i) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ERROR;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE) begin
            lutErr_d = hostAccess;
            if (abort_i) begin
                state_d     = ST_IDLE;
                taskStart_d = 1'b0;
                timeout_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            next_q       <= '0;
            task_q       <= '0;
            repeat_q     <= '0;
            iter_q       <= '0;
            len_q        <= '0;
            last_q       <= 1'b0;
            sof_q        <= 1'b0;
            eof_q        <= 1'b0;
            wdog_q       <= '0;
            taskStart_q  <= 1'b0;
            timeout_q    <= 1'b0;
            lutErr_q     <= 1'b0;
            rdValid_q    <= 1'b0;
            hostRdData_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            next_q       <= next_d;
            task_q       <= task_d;
            repeat_q     <= repeat_d;
            iter_q       <= iter_d;
            len_q        <= len_d;
            last_q       <= last_d;
            sof_q        <= sof_d;
            eof_q        <= eof_d;
            wdog_q       <= wdog_d;
            taskStart_q  <= taskStart_d;
            timeout_q    <= timeout_d;
            lutErr_q     <= lutErr_d;
            rdValid_q    <= rdValid_d;
            hostRdData_q <= hostRdData_d;
        end
    end

    // Fresh read data is shown straight from the RAM, then held in hostRdData_q
    assign lut_rd_data_o   = rdValid_q ? ramRdata : hostRdData_q;
    assign lut_rd_valid_o  = rdValid_q;
    assign lut_err_o       = lutErr_q;
    assign state_o         = state_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign task_o          = task_q;
    assign task_start_o    = taskStart_q;
    assign step_addr_o     = addr_q;
    assign iter_o          = iter_q;
    assign data_length_o   = len_q;
    assign sof_o           = sof_q;
    assign eof_o           = eof_q;
    assign sequence_done_o = (state_q == ST_DONE);
    assign timeout_o       = timeout_q;
    assign error_o         = (state_q == ST_ERROR);

endmodule
